// File: rtl/regfile_param_if.sv
// Register-file access bundle: read ports, write port and scoreboard set port.
// The master drives addresses/enables; the slave (register file) returns read results.
interface regfile_param_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NRD    = 2
);
  logic [NRD-1:0]        rd_en;
  logic [NRD*ADDR_W-1:0] rd_addr;
  logic [NRD*DATA_W-1:0] rd_data;
  logic [NRD-1:0]        rd_valid;
  logic [NRD-1:0]        rd_pend;
  logic                  wr_en;
  logic [ADDR_W-1:0]     wr_addr;
  logic [DATA_W-1:0]     wr_data;
  logic                  sb_set;
  logic [ADDR_W-1:0]     sb_addr;

  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_data, sb_set, sb_addr,
    input  rd_data, rd_valid, rd_pend
  );

  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data, sb_set, sb_addr,
    output rd_data, rd_valid, rd_pend
  );
endinterface

// File: rtl/regfile_param.sv
// Parametrised synchronous-read register file with optional write bypass,
// optional hardwired-zero register and a per-register pending-write scoreboard.
module regfile_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  regfile_param_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0]     mem [DEPTH];
  logic [DEPTH-1:0]      pend;
  logic [DEPTH-1:0]      pend_nxt;
  logic [ADDR_W-1:0]     ra [NRD];
  logic [NRD*DATA_W-1:0] rd_data_q;
  logic [NRD*DATA_W-1:0] rd_data_nxt;
  logic [NRD-1:0]        rd_valid_q;
  logic [NRD-1:0]        rd_pend_q;
  logic [NRD-1:0]        rd_pend_nxt;
  logic                  wr_ok;
  logic                  sb_ok;

  assign wr_ok = bus.wr_en  & ~((ZERO_REG != 0) & (bus.wr_addr == '0));
  assign sb_ok = bus.sb_set & ~((ZERO_REG != 0) & (bus.sb_addr == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_ok) begin
      mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Set is applied after clear so a same-edge set/write leaves the bit pending.
  always_comb begin
    pend_nxt = pend;
    if (wr_ok) pend_nxt[bus.wr_addr] = 1'b0;
    if (sb_ok) pend_nxt[bus.sb_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend <= '0;
    else        pend <= pend_nxt;
  end

  always_comb begin
    for (int unsigned k = 0; k < NRD; k++) ra[k] = bus.rd_addr[k*ADDR_W +: ADDR_W];
  end

  // Zero register takes priority over bypass; disabled ports hold data and pend.
  always_comb begin
    rd_data_nxt = rd_data_q;
    rd_pend_nxt = rd_pend_q;
    for (int unsigned k = 0; k < NRD; k++) begin
      if (bus.rd_en[k]) begin
        if ((ZERO_REG != 0) && (ra[k] == '0)) begin
          rd_data_nxt[k*DATA_W +: DATA_W] = '0;
          rd_pend_nxt[k]                  = 1'b0;
        end else if ((BYPASS != 0) && bus.wr_en && (bus.wr_addr == ra[k])) begin
          rd_data_nxt[k*DATA_W +: DATA_W] = bus.wr_data;
          rd_pend_nxt[k]                  = 1'b0;
        end else begin
          rd_data_nxt[k*DATA_W +: DATA_W] = mem[ra[k]];
          rd_pend_nxt[k]                  = pend[ra[k]];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= '0;
      rd_pend_q  <= '0;
    end else begin
      rd_data_q  <= rd_data_nxt;
      rd_valid_q <= bus.rd_en;
      rd_pend_q  <= rd_pend_nxt;
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_pend  = rd_pend_q;
endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: two 32x32 instances (bypass+zero / neither) share one
// stimulus stream; a 64x64 four-port instance covers the wide configuration.
module tb_regfile_param;
  logic clk;
  logic rst_n;

  logic [1:0]  rd_en;
  logic [9:0]  rd_addr;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        sb_set;
  logic [4:0]  sb_addr;

  logic [3:0]  w_rd_en;
  logic [23:0] w_rd_addr;
  logic        w_wr_en;
  logic [5:0]  w_wr_addr;
  logic [63:0] w_wr_data;
  logic        w_sb_set;
  logic [5:0]  w_sb_addr;

  int checks = 0;
  int passed = 0;

  regfile_param_if #(.DATA_W(32), .ADDR_W(5), .NRD(2)) bus_a ();
  regfile_param_if #(.DATA_W(32), .ADDR_W(5), .NRD(2)) bus_b ();
  regfile_param_if #(.DATA_W(64), .ADDR_W(6), .NRD(4)) bus_w ();

  assign bus_a.rd_en = rd_en;     assign bus_b.rd_en = rd_en;
  assign bus_a.rd_addr = rd_addr; assign bus_b.rd_addr = rd_addr;
  assign bus_a.wr_en = wr_en;     assign bus_b.wr_en = wr_en;
  assign bus_a.wr_addr = wr_addr; assign bus_b.wr_addr = wr_addr;
  assign bus_a.wr_data = wr_data; assign bus_b.wr_data = wr_data;
  assign bus_a.sb_set = sb_set;   assign bus_b.sb_set = sb_set;
  assign bus_a.sb_addr = sb_addr; assign bus_b.sb_addr = sb_addr;

  assign bus_w.rd_en = w_rd_en;
  assign bus_w.rd_addr = w_rd_addr;
  assign bus_w.wr_en = w_wr_en;
  assign bus_w.wr_addr = w_wr_addr;
  assign bus_w.wr_data = w_wr_data;
  assign bus_w.sb_set = w_sb_set;
  assign bus_w.sb_addr = w_sb_addr;

  regfile_param #(.DATA_W(32), .ADDR_W(5), .NRD(2), .ZERO_REG(1), .BYPASS(1)) u_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
  regfile_param #(.DATA_W(32), .ADDR_W(5), .NRD(2), .ZERO_REG(0), .BYPASS(0)) u_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b.slave));
  regfile_param #(.DATA_W(64), .ADDR_W(6), .NRD(4), .ZERO_REG(1), .BYPASS(1)) u_w (
    .clk(clk), .rst_n(rst_n), .bus(bus_w.slave));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference state per configuration: c=0 is bypass+zero-reg, c=1 is plain.
  logic [31:0] m_reg  [2][32];
  logic        m_pend [2][32];
  logic [31:0] e_data [2][2];
  logic        e_valid[2][2];
  logic        e_pend [2][2];

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      for (int r = 0; r < 32; r++) begin
        m_reg[c][r] = '0;
        m_pend[c][r] = 1'b0;
      end
      for (int k = 0; k < 2; k++) begin
        e_data[c][k] = '0; e_valid[c][k] = 1'b0; e_pend[c][k] = 1'b0;
      end
    end
  endtask

  task automatic model_edge();
    logic [4:0] a;
    bit byp, zr;
    for (int c = 0; c < 2; c++) begin
      byp = (c == 0);
      zr  = (c == 0);
      for (int k = 0; k < 2; k++) begin
        e_valid[c][k] = rd_en[k];
        if (rd_en[k]) begin
          a = rd_addr[k*5 +: 5];
          if (zr && a == 0) begin
            e_data[c][k] = '0; e_pend[c][k] = 1'b0;
          end else if (byp && wr_en && wr_addr == a) begin
            e_data[c][k] = wr_data; e_pend[c][k] = 1'b0;
          end else begin
            e_data[c][k] = m_reg[c][a]; e_pend[c][k] = m_pend[c][a];
          end
        end
      end
      if (wr_en && !(zr && wr_addr == 0)) m_reg[c][wr_addr] = wr_data;
      if (wr_en) m_pend[c][wr_addr] = 1'b0;
      if (sb_set && !(zr && sb_addr == 0)) m_pend[c][sb_addr] = 1'b1;
    end
  endtask

  task automatic tick();
    if (rst_n) model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rd_en = '0; rd_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    sb_set = 1'b0; sb_addr = '0;
    w_rd_en = '0; w_rd_addr = '0; w_wr_en = 1'b0; w_wr_addr = '0; w_wr_data = '0;
    w_sb_set = 1'b0; w_sb_addr = '0;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    model_reset();
    #3;
    checks++;
    if ({bus_a.rd_valid, bus_a.rd_pend, bus_a.rd_data, bus_b.rd_valid, bus_b.rd_pend, bus_b.rd_data} !== '0)
      $display("FAIL reset_ab got a=%h/%b/%b b=%h/%b/%b want 0", bus_a.rd_data, bus_a.rd_valid,
               bus_a.rd_pend, bus_b.rd_data, bus_b.rd_valid, bus_b.rd_pend);
    else passed++;
    checks++;
    if ({bus_w.rd_valid, bus_w.rd_pend, bus_w.rd_data} !== '0)
      $display("FAIL reset_w got %h/%b/%b want 0", bus_w.rd_data, bus_w.rd_valid, bus_w.rd_pend);
    else passed++;
    rd_en = 2'b11; rd_addr = {5'd3, 5'd4};
    tick();
    checks++;
    if ({bus_a.rd_valid, bus_b.rd_valid, bus_a.rd_data, bus_b.rd_data} !== '0)
      $display("FAIL reset_hold got va=%b vb=%b want 0", bus_a.rd_valid, bus_b.rd_valid);
    else passed++;
    #2 rst_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      rd_en = 2'b11;
      rd_addr = {5'(31 - i), 5'(i)};
      tick();
      checks++;
      if ({bus_a.rd_valid, bus_a.rd_pend, bus_a.rd_data} !== {2'b11, 2'b00, 64'd0})
        $display("FAIL reset_read_a addr=%0d got %b/%b/%h want 11/00/0", i,
                 bus_a.rd_valid, bus_a.rd_pend, bus_a.rd_data);
      else passed++;
      checks++;
      if ({bus_b.rd_valid, bus_b.rd_pend, bus_b.rd_data} !== {2'b11, 2'b00, 64'd0})
        $display("FAIL reset_read_b addr=%0d got %b/%b/%h want 11/00/0", i,
                 bus_b.rd_valid, bus_b.rd_pend, bus_b.rd_data);
      else passed++;
    end
    idle();
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hDEADBEEF;
    tick();
    idle();
    rd_en = 2'b11; rd_addr = {5'd0, 5'd0};
    tick();
    checks++;
    if (bus_a.rd_data !== 64'd0)
      $display("FAIL zero_reg_a got %h want 0", bus_a.rd_data);
    else passed++;
    checks++;
    if (bus_b.rd_data !== {32'hDEADBEEF, 32'hDEADBEEF})
      $display("FAIL zero_reg_off_b got %h want deadbeefdeadbeef", bus_b.rd_data);
    else passed++;
    idle();
  endtask

  task automatic test_basic();
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h6;
    tick();
    wr_addr = 5'd9; wr_data = 32'h9;
    tick();
    idle();
    rd_en = 2'b11; rd_addr = {5'd9, 5'd5};
    tick();
    checks++;
    if ({bus_a.rd_valid, bus_a.rd_data} !== {2'b11, 32'd9, 32'd6})
      $display("FAIL basic_read_a got %b/%h want 11/0000000900000006", bus_a.rd_valid, bus_a.rd_data);
    else passed++;
    checks++;
    if ({bus_b.rd_valid, bus_b.rd_data} !== {2'b11, 32'd9, 32'd6})
      $display("FAIL basic_read_b got %b/%h want 11/0000000900000006", bus_b.rd_valid, bus_b.rd_data);
    else passed++;
    rd_en = 2'b00; rd_addr = {5'd1, 5'd2};
    tick();
    checks++;
    if ({bus_a.rd_valid, bus_a.rd_data, bus_b.rd_valid, bus_b.rd_data}
        !== {2'b00, 32'd9, 32'd6, 2'b00, 32'd9, 32'd6})
      $display("FAIL basic_hold got va=%b a=%h vb=%b b=%h want 00/9,6", bus_a.rd_valid,
               bus_a.rd_data, bus_b.rd_valid, bus_b.rd_data);
    else passed++;
    idle();
  endtask

  task automatic test_bypass();
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h11;
    tick();
    wr_data = 32'h22; rd_en = 2'b11; rd_addr = {5'd7, 5'd7};
    tick();
    checks++;
    if (bus_a.rd_data !== {32'h22, 32'h22})
      $display("FAIL bypass_on got %h want 0000002200000022", bus_a.rd_data);
    else passed++;
    checks++;
    if (bus_b.rd_data !== {32'h11, 32'h11})
      $display("FAIL bypass_off got %h want 0000001100000011", bus_b.rd_data);
    else passed++;
    wr_en = 1'b0;
    tick();
    checks++;
    if ({bus_a.rd_data, bus_b.rd_data} !== {32'h22, 32'h22, 32'h22, 32'h22})
      $display("FAIL bypass_after got a=%h b=%h want 22 on all", bus_a.rd_data, bus_b.rd_data);
    else passed++;
    idle();
  endtask

  task automatic test_scoreboard();
    sb_set = 1'b1; sb_addr = 5'd3; rd_en = 2'b01; rd_addr = {5'd0, 5'd3};
    tick();
    checks++;
    if ({bus_a.rd_pend[0], bus_b.rd_pend[0]} !== 2'b00)
      $display("FAIL sb_same_edge_old got %b%b want 00", bus_a.rd_pend[0], bus_b.rd_pend[0]);
    else passed++;
    sb_set = 1'b0;
    tick();
    checks++;
    if ({bus_a.rd_pend[0], bus_b.rd_pend[0]} !== 2'b11)
      $display("FAIL sb_set got %b%b want 11", bus_a.rd_pend[0], bus_b.rd_pend[0]);
    else passed++;
    rd_en = 2'b00; wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h33;
    tick();
    wr_en = 1'b0; rd_en = 2'b01;
    tick();
    checks++;
    if ({bus_a.rd_pend[0], bus_b.rd_pend[0]} !== 2'b00)
      $display("FAIL sb_clear got %b%b want 00", bus_a.rd_pend[0], bus_b.rd_pend[0]);
    else passed++;
    rd_en = 2'b00; sb_set = 1'b1; sb_addr = 5'd3; wr_en = 1'b1; wr_data = 32'h44;
    tick();
    sb_set = 1'b0; wr_en = 1'b0; rd_en = 2'b01;
    tick();
    checks++;
    if ({bus_a.rd_pend[0], bus_b.rd_pend[0]} !== 2'b11)
      $display("FAIL sb_set_wins got %b%b want 11", bus_a.rd_pend[0], bus_b.rd_pend[0]);
    else passed++;
    wr_en = 1'b1; wr_data = 32'h55;
    tick();
    checks++;
    if ({bus_a.rd_pend[0], bus_a.rd_data[31:0]} !== {1'b0, 32'h55})
      $display("FAIL sb_bypass_on got %b/%h want 0/00000055", bus_a.rd_pend[0], bus_a.rd_data[31:0]);
    else passed++;
    checks++;
    if ({bus_b.rd_pend[0], bus_b.rd_data[31:0]} !== {1'b1, 32'h44})
      $display("FAIL sb_bypass_off got %b/%h want 1/00000044", bus_b.rd_pend[0], bus_b.rd_data[31:0]);
    else passed++;
    wr_en = 1'b0;
    tick();
    checks++;
    if ({bus_a.rd_pend[0], bus_b.rd_pend[0], bus_a.rd_data[31:0], bus_b.rd_data[31:0]}
        !== {2'b00, 32'h55, 32'h55})
      $display("FAIL sb_after_write got pend=%b%b a=%h b=%h want 00/55/55", bus_a.rd_pend[0],
               bus_b.rd_pend[0], bus_a.rd_data[31:0], bus_b.rd_data[31:0]);
    else passed++;
    rd_en = 2'b00; sb_set = 1'b1; sb_addr = 5'd0;
    tick();
    sb_set = 1'b0; rd_en = 2'b10; rd_addr = {5'd0, 5'd0};
    tick();
    checks++;
    if ({bus_a.rd_pend[1], bus_b.rd_pend[1]} !== 2'b01)
      $display("FAIL sb_zero_reg got a=%b b=%b want a=0 b=1", bus_a.rd_pend[1], bus_b.rd_pend[1]);
    else passed++;
    idle();
  endtask

  task automatic test_random();
    logic [33:0] got, exp;
    for (int n = 0; n < 300; n++) begin
      rd_en   = 2'($urandom_range(0, 3));
      rd_addr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      wr_en   = 1'($urandom_range(0, 1));
      wr_addr = 5'($urandom_range(0, 7));
      wr_data = $urandom;
      sb_set  = ($urandom_range(0, 3) == 0);
      sb_addr = 5'($urandom_range(0, 7));
      tick();
      for (int c = 0; c < 2; c++) begin
        for (int k = 0; k < 2; k++) begin
          got = (c == 0) ? {bus_a.rd_valid[k], bus_a.rd_pend[k], bus_a.rd_data[k*32 +: 32]}
                         : {bus_b.rd_valid[k], bus_b.rd_pend[k], bus_b.rd_data[k*32 +: 32]};
          exp = {e_valid[c][k], e_pend[c][k], e_data[c][k]};
          checks++;
          if (got !== exp)
            $display("FAIL random cyc=%0d cfg=%0d port=%0d got v/p/d=%h want %h", n, c, k, got, exp);
          else passed++;
        end
      end
    end
    idle();
  endtask

  task automatic test_param();
    logic [5:0]  a;
    logic [63:0] exp;
    for (int r = 0; r < 64; r++) begin
      w_wr_en = 1'b1; w_wr_addr = 6'(r); w_wr_data = 64'(r) * 64'h0101010101010101;
      tick();
    end
    idle();
    for (int i = 0; i < 64; i++) begin
      w_rd_en = 4'hF;
      for (int k = 0; k < 4; k++) w_rd_addr[k*6 +: 6] = 6'((i + 16 * k + k) % 64);
      tick();
      checks++;
      if ({bus_w.rd_valid, bus_w.rd_pend} !== 8'hF0)
        $display("FAIL wide_flags i=%0d got v=%b p=%b want 1111/0000", i, bus_w.rd_valid, bus_w.rd_pend);
      else passed++;
      for (int k = 0; k < 4; k++) begin
        a = 6'((i + 16 * k + k) % 64);
        exp = 64'(a) * 64'h0101010101010101;
        checks++;
        if (bus_w.rd_data[k*64 +: 64] !== exp)
          $display("FAIL wide_read i=%0d port=%0d addr=%0d got %h want %h", i, k, a,
                   bus_w.rd_data[k*64 +: 64], exp);
        else passed++;
      end
    end
    idle();
  endtask

  task automatic test_async_reset();
    wr_en = 1'b1; wr_addr = 5'd12; wr_data = 32'hABCD;
    tick();
    wr_en = 1'b0; sb_set = 1'b1; sb_addr = 5'd12;
    tick();
    sb_set = 1'b0; rd_en = 2'b11; rd_addr = {5'd12, 5'd12};
    w_rd_en = 4'hF; w_rd_addr = {4{6'd5}};
    tick();
    checks++;
    if ({bus_a.rd_valid, bus_a.rd_pend, bus_b.rd_data} !== {2'b11, 2'b11, 32'hABCD, 32'hABCD})
      $display("FAIL pre_reset got va=%b pa=%b b=%h want 11/11/abcd", bus_a.rd_valid,
               bus_a.rd_pend, bus_b.rd_data);
    else passed++;
    checks++;
    if (bus_w.rd_valid !== 4'hF)
      $display("FAIL pre_reset_w got v=%b want 1111", bus_w.rd_valid);
    else passed++;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({bus_a.rd_valid, bus_a.rd_pend, bus_a.rd_data, bus_b.rd_valid, bus_b.rd_pend, bus_b.rd_data} !== '0)
      $display("FAIL async_reset_ab got a=%h/%b/%b b=%h/%b/%b want 0", bus_a.rd_data, bus_a.rd_valid,
               bus_a.rd_pend, bus_b.rd_data, bus_b.rd_valid, bus_b.rd_pend);
    else passed++;
    checks++;
    if ({bus_w.rd_valid, bus_w.rd_pend, bus_w.rd_data} !== '0)
      $display("FAIL async_reset_w got %h/%b/%b want 0", bus_w.rd_data, bus_w.rd_valid, bus_w.rd_pend);
    else passed++;
    #2 rst_n = 1'b1;
    tick();
    checks++;
    if ({bus_a.rd_valid, bus_a.rd_pend, bus_a.rd_data, bus_b.rd_valid, bus_b.rd_pend, bus_b.rd_data}
        !== {2'b11, 2'b00, 64'd0, 2'b11, 2'b00, 64'd0})
      $display("FAIL first_read_after_reset got a=%h/%b/%b b=%h/%b/%b want 0/11/00", bus_a.rd_data,
               bus_a.rd_valid, bus_a.rd_pend, bus_b.rd_data, bus_b.rd_valid, bus_b.rd_pend);
    else passed++;
    checks++;
    if ({bus_w.rd_valid, bus_w.rd_data} !== {4'hF, 256'd0})
      $display("FAIL first_read_after_reset_w got v=%b d=%h want 1111/0", bus_w.rd_valid, bus_w.rd_data);
    else passed++;
    idle();
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    test_reset();
    test_basic();
    test_bypass();
    test_scoreboard();
    test_random();
    test_param();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/regfile_param.md
# regfile_param

Parametrised, synchronous-read register file for the MIPS datapath, replacing the fixed 32x32, two-read-port register file. It generalises width, depth and read-port count. It adds an asynchronous active-low reset, per-port read enables with valid flags, optional write-to-read bypass, and an optional hardwired-zero register. A per-register pending-write scoreboard lets the decode stage detect RAW hazards.

## Interface
- DATA_W, 32: register width in bits.
- ADDR_W, 5: address width; depth is 2**ADDR_W.
- NRD, 2: number of read ports, 1..4.
- ZERO_REG, 1: 1 means register 0 reads as 0, ignores writes and is never pending.
- BYPASS, 1: 1 means a same-cycle write is forwarded to a matching read.

- clk  input  1  clock; all state changes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rd_en  input  NRD  per-port read enable.
- rd_addr  input  NRD*ADDR_W  read addresses; port k occupies bits [k*ADDR_W +: ADDR_W].
- rd_data  output  NRD*DATA_W  registered read data; port k occupies bits [k*DATA_W +: DATA_W].
- rd_valid  output  NRD  rd_data for port k was updated by a read on the previous edge.
- rd_pend  output  NRD  the register read on port k had an outstanding write when it was sampled.
- wr_en  input  1  write enable.
- wr_addr  input  ADDR_W  write address.
- wr_data  input  DATA_W  write data.
- sb_set  input  1  mark register sb_addr as pending.
- sb_addr  input  ADDR_W  scoreboard address.

## Operation
- Storage is 2**ADDR_W x DATA_W.
- Reset (rst_n low, asynchronous):
  - all registers are 0;
  - all pending bits are 0;
  - rd_data is 0, rd_valid is 0, rd_pend is 0.
  - All outputs hold these values while rst_n is low.
- Write: on an edge with wr_en=1, reg[wr_addr] is loaded with wr_data. With ZERO_REG=1 and wr_addr=0, the write is dropped.
- Read, per port k:
  - On an edge with rd_en[k]=1:
    - rd_data[k] is loaded with reg[rd_addr[k]];
    - rd_valid[k] is set to 1;
    - rd_pend[k] is loaded with pend[rd_addr[k]].
  - On an edge with rd_en[k]=0: rd_valid[k] goes to 0; rd_data[k] and rd_pend[k] hold their values.
- Bypass:
  - BYPASS=1: when wr_en=1 and wr_addr equals rd_addr[k] on the same edge, rd_data[k] takes wr_data and rd_pend[k] is 0.
  - BYPASS=0: the read returns the pre-write value and the pre-write pending bit.
- Zero register: with ZERO_REG=1, a read of address 0 returns 0 and rd_pend=0, regardless of bypass.
- Scoreboard:
  - sb_set=1 sets pend[sb_addr].
  - wr_en=1 clears pend[wr_addr].
  - If both target the same address on the same edge, set wins and the bit ends at 1.
  - sb_set to address 0 is ignored when ZERO_REG=1.
- All read ports are independent. Any number of ports may read the same address on the same edge.

## Timing
- Read latency is 1 cycle: the address and rd_en presented before edge N appear on rd_data/rd_valid/rd_pend after edge N.
- Write latency is 1 cycle: the write is visible to a non-bypassed read issued on edge N+1 or later.
- Scoreboard update takes effect at the edge. A read on that same edge sees the old pending bit, except for the bypass clear described above.
- No handshake back-pressure: every enabled read completes; rd_valid is a single-cycle pulse per enabled read.
- Reset assertion mid-operation clears everything immediately, without waiting for a clock edge.
- On the first edge after rst_n rises, normal operation resumes. A read issued on that edge returns 0.
- Out-of-range conditions cannot occur: all addresses are full ADDR_W width.

## Test plan
- Reset and zero reg: assert rst_n=0 mid-run, then release. Read all addresses on both ports: rd_data=0, rd_pend=0, rd_valid=1 one cycle after each rd_en. With ZERO_REG=1, write 0xDEADBEEF to reg 0, then read reg 0: result is 0.
- Basic write/read: write reg 5=0x00000006 and reg 9=0x00000009. On the next cycle, read 5 on port 0 and 9 on port 1: after one edge rd_data0=6, rd_data1=9, rd_valid=2'b11. Drop rd_en: rd_valid=0 and data holds.
- Bypass: reg 7=0x11. On the same edge, write 0x22 to reg 7 and read 7 on both ports. BYPASS=1 gives 0x22 on both ports; BYPASS=0 gives 0x11. A read on the next edge gives 0x22 in both configurations.
- Scoreboard:
  - sb_set reg 3, then read 3: rd_pend=1.
  - Write reg 3, then read again: rd_pend=0.
  - sb_set and write to reg 3 on the same edge: pend stays 1.
  - Same-edge write + read of reg 3 with BYPASS=1: rd_pend=0.
- Parametrisation: DATA_W=64, ADDR_W=6, NRD=4. Fill all 64 registers with address*0x0101010101010101, then read them back with all four ports at staggered addresses: every value matches, and no cross-port corruption.
- Async reset mid-read: assert rst_n between edges while rd_valid=1: rd_data, rd_valid and rd_pend go to 0 before the next clk edge.
